// File: rtl/user_obi_rom_arbiter.sv
// Round-robin arbiter funnelling NumChannels read clients onto one OBI manager port with in-order response routing.
// Optional macro USER_OBI_ROM_ARBITER_ERR_EN forwards r.err on ch_err_o and keeps a sticky per-channel error bit.

package user_obi_rom_arbiter_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32'd32, DataWidth: 32'd32};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_def_a_chan_t;

    typedef struct packed {
        obi_def_a_chan_t a;
        logic            req;
    } obi_def_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } obi_def_r_chan_t;

    typedef struct packed {
        obi_def_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } obi_def_rsp_t;

endpackage

// state     | meaning
// ST_IDLE   | selection follows the round-robin pointer every cycle
// ST_LOCKED | req issued without gnt; channel and address frozen until gnt
module user_obi_rom_arbiter #(
    parameter user_obi_rom_arbiter_pkg::obi_cfg_t ObiCfg = user_obi_rom_arbiter_pkg::ObiDefaultConfig,
    parameter type obi_req_t = user_obi_rom_arbiter_pkg::obi_def_req_t,
    parameter type obi_rsp_t = user_obi_rom_arbiter_pkg::obi_def_rsp_t,
    parameter int unsigned NumChannels = 2,
    parameter int unsigned ChAddrWidth = 16,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumChannels-1:0]                  ch_req_i,
    input  logic [NumChannels-1:0][ChAddrWidth-1:0] ch_addr_i,
    output logic [NumChannels-1:0]                  ch_gnt_o,
    output logic [NumChannels-1:0]                  ch_valid_o,
    output logic [ObiCfg.DataWidth-1:0]             ch_data_o,
    output logic                                    ch_err_o,
    output obi_req_t                                obi_req_o,
    input  obi_rsp_t                                obi_rsp_i,
    output logic                                    busy_o
);

    localparam int unsigned PtrW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned FifoW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW  = $clog2(NumMaxTrans + 1);
    localparam int unsigned LockW = ChAddrWidth - 2;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [PtrW-1:0]  rr_sel, sel, head;
    logic [PtrW-1:0]  lock_sel_q, lock_sel_d;
    logic [LockW-1:0] lock_addr_q, lock_addr_d, sel_addr;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [FifoW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PtrW-1:0]  id_q [NumMaxTrans];
    logic [PtrW-1:0]  id_d [NumMaxTrans];

    logic        issue, grant, pop, rr_found;
    int unsigned rr_idx;
    logic [1:0]  unused_addr_lsb;
    logic        unused_rsp;

    function automatic logic [FifoW-1:0] fifo_inc(input logic [FifoW-1:0] p);
        return (32'(p) == NumMaxTrans - 1) ? '0 : p + FifoW'(1);
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == NumChannels - 1) ? '0 : p + PtrW'(1);
    endfunction

    // First requester at or after ptr_q, wrapping around.
    always_comb begin
        rr_sel   = ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            rr_idx = 32'(ptr_q) + i;
            if (rr_idx >= NumChannels) begin
                rr_idx = rr_idx - NumChannels;
            end
            if (!rr_found && ch_req_i[PtrW'(rr_idx)]) begin
                rr_sel   = PtrW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // Uses the registered count only, so a same-cycle pop never frees a slot early.
    assign issue = (|ch_req_i) && (cnt_q < CntW'(NumMaxTrans));
    assign grant = issue & obi_rsp_i.gnt;
    assign pop   = obi_rsp_i.rvalid & (cnt_q != '0);
    assign head  = id_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue && !obi_rsp_i.gnt) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel      = rr_sel;
        sel_addr = ch_addr_i[rr_sel][ChAddrWidth-1:2];
        if (state_q == ST_LOCKED) begin
            sel      = lock_sel_q;
            sel_addr = lock_addr_q;
        end
    end

    always_comb begin
        lock_sel_d  = lock_sel_q;
        lock_addr_d = lock_addr_q;
        if (state_q == ST_IDLE && issue && !obi_rsp_i.gnt) begin
            lock_sel_d  = sel;
            lock_addr_d = sel_addr;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        id_d  = id_q;
        if (grant) begin
            ptr_d       = ptr_inc(sel);
            id_d[wr_q]  = sel;
            wr_d        = fifo_inc(wr_q);
        end
        if (pop) begin
            rd_d = fifo_inc(rd_q);
        end
        cnt_d = cnt_q + CntW'(grant) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            id_q        <= '{default: '0};
            lock_sel_q  <= '0;
            lock_addr_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            id_q        <= id_d;
            lock_sel_q  <= lock_sel_d;
            lock_addr_q <= lock_addr_d;
        end
    end

    always_comb begin
        obi_req_o                           = '0;
        obi_req_o.req                       = issue;
        obi_req_o.a.addr                    = '0;
        obi_req_o.a.addr[ChAddrWidth-1:2]   = sel_addr;
        obi_req_o.a.we                      = 1'b0;
        obi_req_o.a.be                      = '1;
        obi_req_o.a.wdata                   = '0;
        obi_req_o.a.aid                     = '0;
    end

    assign ch_gnt_o   = grant ? (NumChannels'(1) << sel) : '0;
    assign ch_valid_o = pop ? (NumChannels'(1) << head) : '0;
    assign ch_data_o  = obi_rsp_i.r.rdata;
    assign busy_o     = (cnt_q != '0);

    always_comb begin
        unused_addr_lsb = '0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            unused_addr_lsb = unused_addr_lsb ^ ch_addr_i[k][1:0];
        end
    end

`ifdef USER_OBI_ROM_ARBITER_ERR_EN
    logic [NumChannels-1:0] err_q, err_d;

    // A fresh error on the response beats a clear from a same-cycle grant.
    always_comb begin
        err_d = err_q;
        if (grant) begin
            err_d[sel] = 1'b0;
        end
        if (pop && obi_rsp_i.r.err) begin
            err_d[head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ch_err_o   = obi_rsp_i.rvalid & obi_rsp_i.r.err;
    assign unused_rsp = ^{err_q, obi_rsp_i.r.rid, unused_addr_lsb, rr_found};
`else
    assign ch_err_o   = 1'b0;
    assign unused_rsp = ^{obi_rsp_i.r.err, obi_rsp_i.r.rid, unused_addr_lsb, rr_found};
`endif

endmodule

// File: tb/tb_user_obi_rom_arbiter.sv
// Directed bench for user_obi_rom_arbiter; responses are checked against a scoreboard filled at grant time.
module tb_user_obi_rom_arbiter;

    typedef user_obi_rom_arbiter_pkg::obi_def_req_t req_t;
    typedef user_obi_rom_arbiter_pkg::obi_def_rsp_t rsp_t;

`ifdef USER_OBI_ROM_ARBITER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [1:0]       ch_req;
    logic [1:0][15:0] ch_addr;
    logic [1:0]       ch_gnt;
    logic [1:0]       ch_valid;
    logic [31:0]      ch_data;
    logic             ch_err;
    req_t             obi_req;
    rsp_t             obi_rsp;
    logic             busy;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    user_obi_rom_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ch_req_i   (ch_req),
        .ch_addr_i  (ch_addr),
        .ch_gnt_o   (ch_gnt),
        .ch_valid_o (ch_valid),
        .ch_data_o  (ch_data),
        .ch_err_o   (ch_err),
        .obi_req_o  (obi_req),
        .obi_rsp_i  (obi_rsp),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                         input logic gnt, input logic rv, input logic [31:0] rdata, input logic err);
        ch_req           = req;
        ch_addr[0]       = a0;
        ch_addr[1]       = a1;
        obi_rsp.gnt      = gnt;
        obi_rsp.rvalid   = rv;
        obi_rsp.r.rdata  = rdata;
        obi_rsp.r.err    = err;
        obi_rsp.r.rid    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push(input int ch, input logic [31:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(ch_valid), 32'd1 << e.ch);
            chk({tag, "_data"}, ch_data, e.data);
            chk({tag, "_err"}, 32'(ch_err), 32'(ErrEn & obi_rsp.r.err));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("rst_req", 32'(obi_req.req), 32'd0);
        chk("rst_gnt", 32'(ch_gnt), 32'd0);
        chk("rst_valid", 32'(ch_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single channel, grant then response one cycle later
        drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t1_req", 32'(obi_req.req), 32'd1);
        chk("t1_addr", obi_req.a.addr, 32'h0000_0104);
        chk("t1_we", 32'(obi_req.a.we), 32'd0);
        chk("t1_be", 32'(obi_req.a.be), 32'hF);
        chk("t1_wdata", obi_req.a.wdata, 32'd0);
        chk("t1_gnt", 32'(ch_gnt), 32'b01);
        push(0, 32'hCAFE_0001);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
        settle();
        check_rsp("t1_rsp");
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: contention, alternating grants, low address bits forced to zero
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive((k < 4) ? 2'b11 : 2'b00, 16'h0107, 16'h0200, k < 4, k > 0,
                  (k > 0) ? (32'hA000_0000 + 32'(k - 1)) : 32'h0, 1'b0);
            settle();
            if (k > 0) check_rsp($sformatf("t2_rsp%0d", k));
            if (k < 4) begin
                chk($sformatf("t2_gnt%0d", k), 32'(ch_gnt), 32'd1 << (k % 2));
                chk($sformatf("t2_addr%0d", k), obi_req.a.addr, (k % 2) ? 32'h200 : 32'h104);
                push(k % 2, 32'hA000_0000 + 32'(k));
            end
            tick();
        end

        // 3: gnt stall keeps ch1 locked while ch0 joins
        do_reset();
        drive(2'b10, 16'h0107, 16'h0008, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t3_addr_c0", obi_req.a.addr, 32'h8);
        chk("t3_gnt_c0", 32'(ch_gnt), 32'b00);
        tick();
        for (int c = 1; c < 3; c++) begin
            drive(2'b11, 16'h0107, 16'h0008, 1'b0, 1'b0, 32'h0, 1'b0);
            settle();
            chk($sformatf("t3_addr_c%0d", c), obi_req.a.addr, 32'h8);
            chk($sformatf("t3_req_c%0d", c), 32'(obi_req.req), 32'd1);
            chk($sformatf("t3_gnt_c%0d", c), 32'(ch_gnt), 32'b00);
            tick();
        end
        drive(2'b11, 16'h0107, 16'h0008, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t3_gnt_c3", 32'(ch_gnt), 32'b10);
        chk("t3_addr_c3", obi_req.a.addr, 32'h8);
        push(1, 32'h3333_0001);
        tick();
        drive(2'b01, 16'h0107, 16'h0008, 1'b1, 1'b1, 32'h3333_0001, 1'b0);
        settle();
        check_rsp("t3_rsp1");
        chk("t3_gnt_c4", 32'(ch_gnt), 32'b01);
        chk("t3_addr_c4", obi_req.a.addr, 32'h104);
        push(0, 32'h3333_0002);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h3333_0002, 1'b0);
        settle();
        check_rsp("t3_rsp0");
        tick();

        // 4: outstanding limit backpressure
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            settle();
            chk($sformatf("t4_gnt_c%0d", c), 32'(ch_gnt), 32'b01);
            push(0, 32'h4444_0001 + 32'(c));
            tick();
        end
        drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t4_req_full", 32'(obi_req.req), 32'd0);
        chk("t4_gnt_full", 32'(ch_gnt), 32'b00);
        chk("t4_busy_full", 32'(busy), 32'd1);
        tick();
        drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b1, 32'h4444_0001, 1'b0);
        settle();
        chk("t4_req_pop", 32'(obi_req.req), 32'd0);
        check_rsp("t4_rsp1");
        tick();
        drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t4_req_again", 32'(obi_req.req), 32'd1);
        chk("t4_gnt_again", 32'(ch_gnt), 32'b01);
        push(0, 32'h4444_0003);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h4444_0002, 1'b0);
        settle();
        check_rsp("t4_rsp2");
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h4444_0003, 1'b0);
        settle();
        check_rsp("t4_rsp3");
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t4_busy_end", 32'(busy), 32'd0);

        // 5: reset mid-transaction, late response is spurious
        do_reset();
        drive(2'b01, 16'h0100, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t5_gnt_pre", 32'(ch_gnt), 32'b01);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        do_reset();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h0000_DEAD, 1'b0);
        settle();
        chk("t5_spur_valid", 32'(ch_valid), 32'b00);
        chk("t5_spur_busy", 32'(busy), 32'd0);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t5_busy_post", 32'(busy), 32'd0);
        tick();
        drive(2'b01, 16'h0100, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t5_gnt_post", 32'(ch_gnt), 32'b01);
        chk("t5_addr_post", obi_req.a.addr, 32'h100);
        push(0, 32'h5555_0001);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h5555_0001, 1'b0);
        settle();
        check_rsp("t5_rsp");
        tick();

        // 6: error response
        do_reset();
        drive(2'b01, 16'h0104, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t6_gnt", 32'(ch_gnt), 32'b01);
        push(0, 32'h6666_0001);
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 32'h6666_0001, 1'b1);
        settle();
        check_rsp("t6_rsp");
        tick();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
